// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one 16-bit framebuffer RAM port between the
// mono word writer (via a small FIFO) and the display read engine.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   wr_strobe/bits/xaddr/yaddr    incoming dithered word and its position
//   vsync                         frame-start pulse
//   rd_req/rd_addr -> rd_ack      read request handshake
//   rd_valid/rd_data              read data, two cycles after the grant
//   ram_addr/we/wdata, ram_rdata  registered RAM port, 1-cycle read latency
//   frame_drops                   words lost in the previous frame
//   running                       set once the first vsync is seen
module fb_arbiter #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int ADDR_BITS = 15,
    parameter int DEPTH     = 4,
    parameter int URGENT    = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_strobe,
    input  logic [15:0]          wr_bits,
    input  logic [11:0]          wr_xaddr,
    input  logic [11:0]          wr_yaddr,
    input  logic                 vsync,
    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_ack,
    output logic                 rd_valid,
    output logic [15:0]          rd_data,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_we,
    output logic [15:0]          ram_wdata,
    input  logic [15:0]          ram_rdata,
    output logic [15:0]          frame_drops,
    output logic                 running
);

    localparam int WORDS = WIDTH / 16;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int EW    = ADDR_BITS + 16;

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic                 state;
    logic [EW-1:0]        mem [DEPTH];
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic [CW-1:0]        count;
    logic [15:0]          drop_cnt;
    logic                 rd_pend;

    logic                 urgent;
    logic                 rd_grant;
    logic                 wr_grant;
    logic                 in_bounds;
    logic                 full;
    logic                 try_push;
    logic                 push;
    logic                 drop;
    logic [ADDR_BITS-1:0] waddr;
    logic [EW-1:0]        head;
    logic                 unused_xlow;

    // The sub-word pixel offset carries no information for word addressing.
    assign unused_xlow = ^wr_xaddr[3:0];

    assign waddr = ADDR_BITS'(32'(wr_yaddr) * WORDS
                              + 32'(wr_xaddr[11:4]));

    assign in_bounds = (32'(wr_yaddr) < HEIGHT)
                    && (32'(wr_xaddr[11:4]) < WORDS);

    // Reads win unless the FIFO is close to overflowing.
    assign urgent   = count >= CW'(URGENT);
    assign rd_grant = !urgent && rd_req;
    assign wr_grant = urgent || (!rd_req && count != '0);

    assign full     = count == CW'(DEPTH);
    assign try_push = (state == RUN) && wr_strobe && in_bounds;
    // A full FIFO still accepts a word when the head leaves this cycle.
    assign push     = try_push && (!full || wr_grant);
    assign drop     = try_push && !push;

    assign head    = mem[rptr];
    assign rd_ack  = rd_grant && reset_n;
    assign running = (state == RUN);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {waddr, wr_bits};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            drop_cnt    <= '0;
            frame_drops <= '0;
            rd_pend     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end

            if (wr_grant) begin
                rptr      <= rptr + 1'b1;
                ram_we    <= 1'b1;
                ram_addr  <= head[EW-1:16];
                ram_wdata <= head[15:0];
            end else begin
                ram_we <= 1'b0;
                if (rd_grant) begin
                    ram_addr <= rd_addr;
                end
            end

            if (push && !wr_grant) begin
                count <= count + 1'b1;
            end else if (!push && wr_grant) begin
                count <= count - 1'b1;
            end

            rd_pend  <= rd_grant;
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= ram_rdata;
            end

            if (state == IDLE && vsync) begin
                state <= RUN;
            end

            // A drop coinciding with vsync belongs to the new frame.
            if (state == RUN && vsync) begin
                frame_drops <= drop_cnt;
                drop_cnt    <= {15'd0, drop};
            end else if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against a queue-based model of the arbiter.
module tb_fb_arbiter;

    localparam int AB     = 15;
    localparam int DEPTH  = 4;
    localparam int URGENT = 3;
    localparam int WORDS  = 40;
    localparam int HEIGHT = 480;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_strobe;
    logic [15:0]   wr_bits;
    logic [11:0]   wr_xaddr;
    logic [11:0]   wr_yaddr;
    logic          vsync;
    logic          rd_req;
    logic [AB-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [15:0]   rd_data;
    logic [AB-1:0] ram_addr;
    logic          ram_we;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;
    logic [15:0]   frame_drops;
    logic          running;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [AB-1:0] a);
        if (a == AB'(100)) return 16'h1234;
        return {1'b0, a} ^ 16'hC3C3;
    endfunction

    assign ram_rdata = rom(ram_addr);

    fb_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_strobe  (wr_strobe),
        .wr_bits    (wr_bits),
        .wr_xaddr   (wr_xaddr),
        .wr_yaddr   (wr_yaddr),
        .vsync      (vsync),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .frame_drops(frame_drops),
        .running    (running)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: pending words, frame status, expected RAM port.
    logic [AB+15:0] q[$];
    logic [AB-1:0]  wlog[$];
    bit             m_run;
    int             m_drops;
    int             m_fd;
    bit             m_we;
    logic [AB-1:0]  m_addr;
    logic [15:0]    m_wdata;
    bit             m_pend;
    bit             m_rv;
    logic [15:0]    m_rdata;
    bit             m_ack;

    task automatic step();
        int n;
        bit rg;
        bit wg;
        bit dropped;
        @(negedge clk);
        n  = q.size();
        rg = (n < URGENT) && rd_req;
        wg = !rg && n > 0;
        m_ack = reset_n && rg;
        check("rd_ack", rd_ack, m_ack);
        dropped = 0;
        if (!reset_n) begin
            q.delete();
            m_run = 0; m_drops = 0; m_fd = 0;
            m_we = 0; m_addr = '0; m_wdata = '0;
            m_pend = 0; m_rv = 0; m_rdata = '0;
        end else begin
            m_rv = m_pend;
            if (m_pend) m_rdata = rom(m_addr);
            m_pend = rg;
            if (wg) begin
                {m_addr, m_wdata} = q.pop_front();
                m_we = 1;
            end else begin
                m_we = 0;
                if (rg) m_addr = rd_addr;
            end
            if (m_run && wr_strobe && int'(wr_yaddr) < HEIGHT
                && int'(wr_xaddr[11:4]) < WORDS) begin
                if (q.size() < DEPTH)
                    q.push_back({AB'(int'(wr_yaddr) * WORDS
                                     + int'(wr_xaddr[11:4])), wr_bits});
                else
                    dropped = 1;
            end
            if (vsync && m_run) begin
                m_fd    = m_drops;
                m_drops = int'(dropped);
            end else if (dropped && m_drops < 65535) begin
                m_drops++;
            end
            if (vsync) m_run = 1;
        end
        @(posedge clk);
        #1;
        check("ram_we", ram_we, m_we);
        check("ram_addr", ram_addr, m_addr);
        check("ram_wdata", ram_wdata, m_wdata);
        check("rd_valid", rd_valid, m_rv);
        check("rd_data", rd_data, m_rdata);
        check("frame_drops", frame_drops, m_fd);
        check("running", running, m_run);
        if (ram_we) wlog.push_back(ram_addr);
    endtask

    task automatic strobe(input logic [11:0] x, input logic [11:0] y,
                          input logic [15:0] b);
        wr_strobe = 1'b1;
        wr_xaddr  = x;
        wr_yaddr  = y;
        wr_bits   = b;
    endtask

    initial begin
        reset_n = 1'b0; wr_strobe = 1'b0; wr_bits = '0;
        wr_xaddr = '0; wr_yaddr = '0; vsync = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        step();
        step();
        reset_n = 1'b1;
        check("rst_we", ram_we, 0);
        check("rst_drops", frame_drops, 0);
        check("rst_running", running, 0);

        // Strobes before the first vsync are ignored.
        for (int i = 0; i < 4; i++) begin
            strobe(12'(i * 16), 12'd5, 16'(i + 16'h77));
            step();
        end
        wr_strobe = 1'b0;
        repeat (3) step();
        check("t1_running", running, 0);
        check("t1_nowrite", wlog.size(), 0);

        vsync = 1'b1;
        step();
        vsync = 1'b0;
        check("t2_running", running, 1);
        strobe(12'h020, 12'd2, 16'hA5A5);
        step();
        wr_strobe = 1'b0;
        step();
        check("t2_we", ram_we, 1);
        check("t2_addr", ram_addr, 82);
        check("t2_data", ram_wdata, 16'hA5A5);

        step();
        rd_req  = 1'b1;
        rd_addr = AB'(100);
        #1;
        check("t3_ack", rd_ack, 1);
        step();
        rd_req = 1'b0;
        step();
        check("t3_valid", rd_valid, 1);
        check("t3_data", rd_data, 16'h1234);

        wlog.delete();
        rd_req  = 1'b1;
        rd_addr = AB'(200);
        for (int i = 0; i < 3; i++) begin
            strobe(12'(i * 16), 12'd1, 16'(16'hB000 + i));
            step();
        end
        wr_strobe = 1'b0;
        check("t4_first_write", wlog.size(), 0);
        step();
        check("t4_urgent_write", wlog.size(), 1);
        repeat (3) step();
        rd_req = 1'b0;
        repeat (4) step();
        check("t4_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("t4_order0", wlog[0], 40);
            check("t4_order1", wlog[1], 41);
            check("t4_order2", wlog[2], 42);
        end

        // With URGENT below DEPTH the head leaves whenever it could fill.
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            strobe(12'(i * 16), 12'd3, 16'($urandom));
            step();
        end
        wr_strobe = 1'b0;
        vsync = 1'b1;
        step();
        vsync  = 1'b0;
        rd_req = 1'b0;
        step();
        check("t5_drops", frame_drops, 0);
        repeat (4) step();

        wlog.delete();
        strobe(12'h000, 12'd480, 16'h1111);
        step();
        strobe(12'h280, 12'd0, 16'h2222);
        step();
        wr_strobe = 1'b0;
        repeat (3) step();
        check("t6_oob", wlog.size(), 0);
        rd_req = 1'b1;
        strobe(12'h010, 12'd7, 16'h3333);
        step();
        strobe(12'h020, 12'd7, 16'h4444);
        step();
        wr_strobe = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        rd_req  = 1'b0;
        wlog.delete();
        repeat (4) step();
        check("t6_stale", wlog.size(), 0);
        check("t6_running", running, 0);

        vsync = 1'b1;
        step();
        vsync = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset_n   = ($urandom % 500) != 0;
            wr_strobe = $urandom % 2;
            wr_xaddr  = 12'($urandom_range(0, 12'h2A0));
            wr_yaddr  = 12'($urandom_range(0, 500));
            wr_bits   = 16'($urandom);
            vsync     = ($urandom % 64) == 0;
            if (!rd_req || m_ack) begin
                rd_req  = ($urandom % 3) == 0;
                rd_addr = AB'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
